ov_cfg_sequencer: RTL and testbench

- Walks the sensor configuration ROM (24-bit words: {reg_addr[15:0], reg_data[7:0]}) from index 0 to LAST_ADDR.
- Converts each non-zero word into a write command for the downstream SCCB/I2C master.
- Treats zero words as wait slots and applies the mandatory settle delay after the sensor software-reset write.
- Sits between the config ROM and the SCCB master; asserts done once the sensor is fully programmed and streaming.

---
 rtl/ov_cfg_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ov_cfg_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov_cfg_sequencer.sv
// ov_cfg_sequencer
//   Walks the sensor configuration ROM from index 0 to LAST_ADDR and turns
//   every non-zero 24-bit word {reg_addr[15:0], reg_data[7:0]} into a write
//   command for the downstream SCCB/I2C master. A zero word is a wait slot:
//   the first zero of a run waits GAP_WAIT cycles and later zeros in the same
//   run pass straight through. A write of data bit0=1 to register 16'h0103
//   (sensor software reset) is followed by a RST_WAIT cycle settle delay.
//   A NACKed write is re-issued up to MAX_RETRY times before the block stops
//   with error set.
//
// Ports
//   clock, reset   system clock, asynchronous active-high reset
//   start          one-cycle pulse; honoured in IDLE, DONE and ERR
//   rom_en         ROM read enable (one cycle per fetch)
//   rom_addr       ROM index
//   rom_data       ROM word, valid the cycle after rom_en
//   cmd_valid      write command valid
//   cmd_ready      SCCB master accepts the command
//   cmd_reg        sensor register address
//   cmd_dat        sensor register data
//   cmd_done       transaction finished (pulse)
//   cmd_nack       qualifies cmd_done; 1 = slave NACK
//   busy           sequence in progress
//   done           sequence completed (held until next start)
//   error          retries exhausted (held until next start)
//   fail_idx       ROM index of the entry that exhausted its retries
//   state_dbg      current FSM state
//
// Command handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both high. Once cmd_valid rises it stays high, with cmd_reg
// and cmd_dat unchanged, until that edge; cmd_ready may stay low for any
// number of cycles. Completion is reported separately through cmd_done.
//
// GAP_WAIT and RST_WAIT must be at least 1.

module ov_cfg_sequencer #(
    parameter logic [8:0]  LAST_ADDR = 9'h10e,
    parameter logic [19:0] GAP_WAIT  = 20'd100000,
    parameter logic [19:0] RST_WAIT  = 20'd200000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        rom_en,
    output logic [8:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_reg,
    output logic [7:0]  cmd_dat,
    input  logic        cmd_done,
    input  logic        cmd_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  fail_idx,
    output logic [3:0]  state_dbg
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] LATCH    = 4'd2;
    localparam logic [3:0] ISSUE    = 4'd3;
    localparam logic [3:0] WAIT_ACK = 4'd4;
    localparam logic [3:0] GAP      = 4'd5;
    localparam logic [3:0] RST      = 4'd6;
    localparam logic [3:0] NEXT     = 4'd7;
    localparam logic [3:0] DONE     = 4'd8;
    localparam logic [3:0] ERR      = 4'd9;

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [3:0]    state;
    logic [8:0]    idx;
    logic [23:0]   word;
    logic [19:0]   cnt;
    logic [RW-1:0] retry;
    logic          gap_armed;
    logic          soft_rst_write;

    // Software-reset write: register 0x0103 with data bit0 set.
    assign soft_rst_write = (word[23:8] == 16'h0103) && word[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 9'd0;
            word      <= 24'd0;
            cnt       <= 20'd0;
            retry     <= '0;
            gap_armed <= 1'b1;
            fail_idx  <= 9'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= FETCH;
                        idx       <= 9'd0;
                        fail_idx  <= 9'd0;
                        gap_armed <= 1'b1;
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    word <= rom_data;
                    if (rom_data == 24'd0) begin
                        // Only the first zero of a run costs the long gap.
                        if (gap_armed) begin
                            state     <= GAP;
                            cnt       <= GAP_WAIT - 20'd1;
                            gap_armed <= 1'b0;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        state     <= ISSUE;
                        gap_armed <= 1'b1;
                        retry     <= '0;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (cmd_done) begin
                        if (!cmd_nack) begin
                            if (soft_rst_write) begin
                                state <= RST;
                                cnt   <= RST_WAIT - 20'd1;
                            end else begin
                                state <= NEXT;
                            end
                        end else if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            state <= ISSUE;
                        end else begin
                            state    <= ERR;
                            fail_idx <= idx;
                        end
                    end
                end
                // Counter is loaded with N-1 so the state lasts exactly N cycles.
                GAP, RST: begin
                    if (cnt == 20'd0) state <= NEXT;
                    else              cnt   <= cnt - 20'd1;
                end
                NEXT: begin
                    if (idx == LAST_ADDR) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 9'd1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode straight from registered state so reset clears
    // cmd_valid, busy and done without waiting for a clock edge.
    assign rom_en    = (state == FETCH);
    assign rom_addr  = idx;
    assign cmd_valid = (state == ISSUE);
    assign cmd_reg   = word[23:8];
    assign cmd_dat   = word[7:0];
    assign busy      = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign state_dbg = state;

endmodule

// File: tb/tb_ov_cfg_sequencer.sv
module tb_ov_cfg_sequencer;

    localparam logic [8:0]  LAST      = 9'h10e;
    localparam logic [19:0] GAP_N     = 20'd16;
    localparam logic [19:0] RST_N     = 20'd32;
    localparam logic [3:0]  S_IDLE    = 4'd0;
    localparam logic [3:0]  S_WAIT    = 4'd4;
    localparam logic [3:0]  S_GAP     = 4'd5;
    localparam logic [3:0]  S_RST     = 4'd6;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rom_en;
    logic [8:0]  rom_addr;
    logic [23:0] rom_data = 24'd0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [15:0] cmd_reg;
    logic [7:0]  cmd_dat;
    logic        cmd_done = 1'b0;
    logic        cmd_nack = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  fail_idx;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    ov_cfg_sequencer #(
        .LAST_ADDR(LAST),
        .GAP_WAIT (GAP_N),
        .RST_WAIT (RST_N),
        .MAX_RETRY(2)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .start    (start),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_reg  (cmd_reg),
        .cmd_dat  (cmd_dat),
        .cmd_done (cmd_done),
        .cmd_nack (cmd_nack),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .fail_idx (fail_idx),
        .state_dbg(state_dbg)
    );

    // ---------------- ROM model ----------------
    logic [23:0] rom [0:270];

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    // ---------------- scoreboard / counters ----------------
    logic [23:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic build_exp(input int upto, input int copies5);
        exp_q.delete();
        for (int i = 0; i <= upto; i++) begin
            if (rom[i] != 24'd0) begin
                for (int c = 0; c < ((i == 5) ? copies5 : 1); c++) exp_q.push_back(rom[i]);
            end
        end
    endtask

    // ---------------- responder / monitor ----------------
    int         cyc = 0;
    int         done_cnt = 0;
    int         t23 = 0, t24 = 0, t30 = 0, t_done0 = 0, t_fetch1 = 0;
    int         gap_cyc = 0, rst_cyc = 0;
    int         bp_left = 0, bp_cyc = 0, bp_bad = 0;
    int         nack_left = 0;
    logic [8:0] cur_idx = 9'd0;
    logic [8:0] nack_idx = 9'd5;
    logic [8:0] bp_idx = 9'd2;
    logic [23:0] exp_w;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            done_cnt  = 0;
            cmd_done  = 1'b0;
            cmd_nack  = 1'b0;
            cmd_ready = 1'b1;
        end else begin
            if (rom_en) begin
                cur_idx = rom_addr;
                if (rom_addr == 9'h23) t23 = cyc;
                if (rom_addr == 9'h24) t24 = cyc;
                if (rom_addr == 9'h30) t30 = cyc;
                if (rom_addr == 9'h01) t_fetch1 = cyc;
            end
            if (state_dbg == S_GAP) gap_cyc++;
            if (state_dbg == S_RST) rst_cyc++;

            cmd_done = 1'b0;
            cmd_nack = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    cmd_done = 1'b1;
                    if (cur_idx == nack_idx && nack_left > 0) begin
                        cmd_nack = 1'b1;
                        nack_left--;
                    end
                    if (cur_idx == 9'd0) t_done0 = cyc;
                end
            end

            if (bp_left > 0 && bp_left < 50 && !cmd_valid) bp_bad++;
            if (cmd_valid && cur_idx == bp_idx && bp_left > 0) begin
                cmd_ready = 1'b0;
                bp_left--;
                bp_cyc++;
                if (cmd_reg != 16'h300f || cmd_dat != 8'h11) bp_bad++;
            end else begin
                cmd_ready = 1'b1;
            end

            // Handshake happens at the coming posedge.
            if (cmd_valid && cmd_ready) begin
                done_cnt = 4;
                if (exp_q.size() == 0) begin
                    check("cmd_extra", {8'h0, cmd_reg, cmd_dat}, 32'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("cmd", {8'h0, cmd_reg, cmd_dat}, {8'h0, exp_w});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done || error) break;
        end
        check("run_end_timeout", {31'b0, done | error}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i <= 270; i++) rom[i] = {16'h3100 + 16'(i), 8'(i)};
        rom[0]      = 24'h0103_01;
        rom[1]      = 24'h030a_00;
        rom[2]      = 24'h300f_11;
        rom[5]      = 24'h3012_41;
        for (int i = 9'h23; i <= 9'h2f; i++) rom[i] = 24'd0;
        rom[9'h30]  = 24'h3615_08;
        rom[9'h10e] = 24'h0100_01;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_flags", {27'b0, rom_en, cmd_valid, busy, done, error}, 32'h0);
        check("rst_addr", {23'b0, rom_addr}, 32'h0);
        check("rst_cmd", {8'h0, cmd_reg, cmd_dat}, 32'h0);
        check("rst_fail_idx", {23'b0, fail_idx}, 32'h0);
        check("rst_state", {28'b0, state_dbg}, {28'b0, S_IDLE});
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Run 1: full walk, two NACKs on index 5, backpressure on index 2,
        // stray start mid-walk.
        build_exp(int'(LAST), 3);
        nack_left = 2;
        bp_left   = 50;
        gap_cyc   = 0;
        rst_cyc   = 0;
        pulse_start();
        for (int k = 0; k < 5000 && cur_idx != 9'h50; k++) @(negedge clk);
        check("reach_idx50", {23'b0, cur_idx}, 32'h50);
        pulse_start();
        wait_end(20000);
        check("run1_done", {29'b0, done, busy, error}, 32'b100);
        check("run1_all_cmds", exp_q.size(), 32'd0);
        check("gap_cycles", gap_cyc, 32'd16);
        check("gap_interval_23_24", t24 - t23, 32'd19);
        check("zero_run_24_30", t30 - t24, 32'd36);
        check("rst_cycles", rst_cyc, 32'd32);
        check("rst_done_to_fetch1", t_fetch1 - t_done0, 32'd34);
        check("bp_cycles", bp_cyc, 32'd50);
        check("bp_stable", bp_bad, 32'd0);

        // Run 2: restart from DONE, index 5 NACKed three times.
        build_exp(5, 3);
        nack_left = 3;
        pulse_start();
        check("restart_flags", {29'b0, done, busy, rom_en}, 32'b011);
        check("restart_addr", {23'b0, rom_addr}, 32'h0);
        wait_end(5000);
        check("run2_flags", {29'b0, done, busy, error}, 32'b001);
        check("run2_fail_idx", {23'b0, fail_idx}, 32'h5);
        repeat (30) @(negedge clk);
        check("run2_all_cmds", exp_q.size(), 32'd0);
        check("run2_idle_valid", {30'b0, cmd_valid, error}, 32'b01);

        // Run 3: restart from ERR, reset while waiting on index 0x40.
        build_exp(int'(LAST), 1);
        nack_left = 0;
        bp_left   = 0;
        pulse_start();
        check("err_cleared", {30'b0, error, {1'b0}}, 32'b0);
        for (int k = 0; k < 5000 && !(state_dbg == S_WAIT && cur_idx == 9'h40); k++) @(negedge clk);
        check("reach_wait_40", {23'b0, cur_idx}, 32'h40);
        #1 reset = 1'b1;
        #1;
        check("midrst_flags", {28'b0, cmd_valid, busy, done, rom_en}, 32'h0);
        check("midrst_state", {28'b0, state_dbg}, {28'b0, S_IDLE});
        @(negedge clk);
        reset = 1'b0;
        build_exp(int'(LAST), 1);
        pulse_start();
        check("rerun_fetch0", {22'b0, rom_en, rom_addr}, {22'b0, 1'b1, 9'h0});
        wait_end(20000);
        check("run3_done", {29'b0, done, busy, error}, 32'b100);
        check("run3_all_cmds", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
